branch_target_buffer: RTL and testbench
=======================================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of direct-mapped entries (power of two, 2..256).
REQ-002 SHALL have parameter CTR_INIT, default 2'b01, counter value loaded at reset.
REQ-003 SHALL have port CLK  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port nRST  input  1  synchronous active-low reset.
REQ-005 SHALL have port lookup_en  input  1  IF-stage fetch accepted this cycle (ihit, not stalled).
REQ-006 SHALL have port lookup_pc  input  32  fetch PC.
REQ-007 SHALL have port pred_hit  output  1  lookup_pc matches a valid entry.
REQ-008 SHALL have port pred_taken  output  1  pred_hit and counter MSB set.
REQ-009 SHALL have port pred_target  output  32  stored target on hit, else lookup_pc+4.
REQ-010 SHALL have port upd_valid  input  1  resolved branch/jump from MEM stage this cycle.
REQ-011 SHALL have ports upd_pc (input, 32, PC of resolved instruction), upd_taken (input, 1, actual direction) and upd_target (input, 32, actual taken target).
REQ-012 SHALL have port upd_mispredict  input  1  pipeline flushed for this resolution.

Function
REQ-013 SHALL derive IDX_W = log2(ENTRIES); index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]; pc[1:0] ignored.
REQ-014 SHALL drive pred_* combinationally from lookup_pc and current table state, zero-cycle latency.
REQ-015 SHALL, when lookup_en=0, still drive pred_* (lookup_en gates statistics only).
REQ-016 SHALL apply an update at the rising edge following upd_valid=1; the new state is visible to lookups in the next cycle.
REQ-017 SHALL, on update hit with upd_taken=1, increment the 2-bit counter saturating at 3 and overwrite the target.
REQ-018 SHALL, on update hit with upd_taken=0, decrement the counter saturating at 0 and keep the target.
REQ-019 SHALL, on update miss with upd_taken=1, allocate: valid=1, new tag, target=upd_target, counter=2'b10, replacing any occupant.
REQ-020 SHALL, on update miss with upd_taken=0, leave the table unchanged.
REQ-021 SHALL, for a same-cycle lookup and update to the same index, return pre-update contents (no bypass).
REQ-022 SHALL change no state when upd_valid=0, whatever the other upd_* inputs are.

Reset
REQ-023 SHALL, while nRST=0 at a rising edge, clear all valid bits, set all counters to CTR_INIT and clear statistics.
REQ-024 SHALL discard an update presented in the same cycle as reset.
REQ-025 SHALL produce pred_hit=0, pred_taken=0 and pred_target=lookup_pc+4 from the first edge after reset.
REQ-026 SHALL leave tag and target storage contents unspecified after reset, guarded by the valid bit.

Configuration
REQ-027 SHALL, with BTB_PERF_EN defined, add outputs perf_hits[31:0], perf_updates[31:0] and perf_mispredicts[31:0].
REQ-028 SHALL make these counters increment on lookup_en&pred_hit, upd_valid and upd_valid&upd_mispredict respectively.
REQ-029 SHALL make each counter saturate at 32'hFFFFFFFF.
REQ-030 SHALL, without BTB_PERF_EN, omit these ports and counters; all other behaviour stays identical.

Structure
REQ-031 SHALL place btb_entry_t (valid, tag, target, ctr) and counter constants (STRONG_NT=0, WEAK_NT=1, WEAK_T=2, STRONG_T=3) in cpu_types_pkg, using word_t for PCs and targets.
REQ-032 SHALL implement counter next-state in sub-module btb_sat_ctr (2-bit current value and taken in, 2-bit next value out), instanced once on the update path.

Verification
REQ-033 SHALL cover: reset, then lookup_pc=0x40 -> pred_hit=0, pred_target=0x44.
REQ-034 SHALL cover: update pc=0x40 taken target=0x100, next cycle lookup 0x40 -> hit=1, taken=1, target=0x100.
REQ-035 SHALL cover: three not-taken updates on 0x40 -> counter 2,1,0,0 (saturates); pred_taken=0 after the first and stays 0; hit stays 1.
REQ-036 SHALL cover: with ENTRIES=16, taken update at 0x40 then taken update at 0x80 (same index, different tag) -> lookup 0x40 misses, 0x80 hits.
REQ-037 SHALL cover: same-cycle lookup and update at 0x40 -> lookup shows old state; the following cycle shows new state.
REQ-038 SHALL cover: with BTB_PERF_EN, 5 mispredicting updates and 3 hit lookups -> perf_updates=5, perf_mispredicts=5, perf_hits=3; reset mid-run zeroes all three.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, BTB entry layout and 2-bit branch counter encodings.
`default_nettype none

package cpu_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [1:0]  ctr_t;

   localparam ctr_t STRONG_NT = 2'd0;
   localparam ctr_t WEAK_NT   = 2'd1;
   localparam ctr_t WEAK_T    = 2'd2;
   localparam ctr_t STRONG_T  = 2'd3;

   // Tag is held word-wide, right-justified, so the layout is independent of ENTRIES.
   typedef struct packed {
      logic  valid;
      word_t tag;
      word_t target;
      ctr_t  ctr;
   } btb_entry_t;

endpackage

`default_nettype wire

// File: rtl/btb_sat_ctr.sv
// Next-state logic of a 2-bit saturating branch-direction counter.
`default_nettype none

module btb_sat_ctr
   import cpu_types_pkg::*;
(
   input  ctr_t i_ctr,
   input  logic i_taken,
   output ctr_t o_ctr
);

   always_comb begin
      o_ctr = i_ctr;
      if (i_taken) begin
         if (i_ctr != STRONG_T) o_ctr = i_ctr + 2'd1;
      end else begin
         if (i_ctr != STRONG_NT) o_ctr = i_ctr - 2'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Optional statistics counters are enabled by defining BTB_PERF_EN.
`default_nettype none

module branch_target_buffer
   import cpu_types_pkg::*;
#(
   parameter int         ENTRIES  = 16,
   parameter logic [1:0] CTR_INIT = 2'b01
)(
   input  logic        CLK,
   input  logic        nRST,
   input  logic        lookup_en,
   input  logic [31:0] lookup_pc,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_mispredict
`ifdef BTB_PERF_EN
   ,
   output logic [31:0] perf_hits,
   output logic [31:0] perf_updates,
   output logic [31:0] perf_mispredicts
`endif
);

   localparam int IDX_W  = $clog2(ENTRIES);
   localparam int TAG_SH = IDX_W + 2;

   btb_entry_t r_table [ENTRIES];

   logic [IDX_W-1:0] w_lk_idx;
   word_t            w_lk_tag;
   btb_entry_t       w_lk_entry;

   logic [IDX_W-1:0] w_upd_idx;
   word_t            w_upd_tag;
   btb_entry_t       w_upd_entry;
   logic             w_upd_hit;
   ctr_t             w_upd_ctr_nxt;

   assign w_lk_idx   = lookup_pc[IDX_W+1:2];
   assign w_lk_tag   = lookup_pc >> TAG_SH;
   assign w_lk_entry = r_table[w_lk_idx];

   // Lookup reads the registered table only, so a same-cycle update is not visible yet.
   always_comb begin
      pred_hit    = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag);
      pred_taken  = pred_hit && w_lk_entry.ctr[1];
      pred_target = pred_hit ? w_lk_entry.target : (lookup_pc + 32'd4);
   end

   assign w_upd_idx   = upd_pc[IDX_W+1:2];
   assign w_upd_tag   = upd_pc >> TAG_SH;
   assign w_upd_entry = r_table[w_upd_idx];
   assign w_upd_hit   = w_upd_entry.valid && (w_upd_entry.tag == w_upd_tag);

   btb_sat_ctr u_sat_ctr (
      .i_ctr   (w_upd_entry.ctr),
      .i_taken (upd_taken),
      .o_ctr   (w_upd_ctr_nxt)
   );

   // Tag and target are left unreset; the valid bit guards them.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_table[i].valid <= 1'b0;
            r_table[i].ctr   <= CTR_INIT;
         end
      end else if (upd_valid) begin
         if (w_upd_hit) begin
            r_table[w_upd_idx].ctr <= w_upd_ctr_nxt;
            if (upd_taken) r_table[w_upd_idx].target <= upd_target;
         end else if (upd_taken) begin
            r_table[w_upd_idx] <= '{valid: 1'b1, tag: w_upd_tag, target: upd_target, ctr: WEAK_T};
         end
      end
   end

`ifdef BTB_PERF_EN
   logic [31:0] r_perf_hits;
   logic [31:0] r_perf_updates;
   logic [31:0] r_perf_mispredicts;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_perf_hits        <= '0;
         r_perf_updates     <= '0;
         r_perf_mispredicts <= '0;
      end else begin
         if (lookup_en && pred_hit && (r_perf_hits != 32'hFFFF_FFFF))
            r_perf_hits <= r_perf_hits + 32'd1;
         if (upd_valid && (r_perf_updates != 32'hFFFF_FFFF))
            r_perf_updates <= r_perf_updates + 32'd1;
         if (upd_valid && upd_mispredict && (r_perf_mispredicts != 32'hFFFF_FFFF))
            r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
      end
   end

   assign perf_hits        = r_perf_hits;
   assign perf_updates     = r_perf_updates;
   assign perf_mispredicts = r_perf_mispredicts;
`else
   logic w_unused_perf;
   assign w_unused_perf = lookup_en ^ upd_mispredict;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer (ENTRIES=16): driver queues expected lookups, monitor checks them.
`default_nettype none

module tb_branch_target_buffer;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        lookup_en = 1'b0;
   logic [31:0] lookup_pc = '0;
   logic        pred_hit, pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_pc = '0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_target = '0;
   logic        upd_mispredict = 1'b0;
`ifdef BTB_PERF_EN
   logic [31:0] perf_hits, perf_updates, perf_mispredicts;
`endif

   branch_target_buffer #(.ENTRIES(16), .CTR_INIT(2'b01)) dut (
      .CLK            (CLK),
      .nRST           (nRST),
      .lookup_en      (lookup_en),
      .lookup_pc      (lookup_pc),
      .pred_hit       (pred_hit),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_taken      (upd_taken),
      .upd_target     (upd_target),
      .upd_mispredict (upd_mispredict)
`ifdef BTB_PERF_EN
      ,
      .perf_hits        (perf_hits),
      .perf_updates     (perf_updates),
      .perf_mispredicts (perf_mispredicts)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [31:0] pc;
      logic        hit;
      logic        taken;
      logic [31:0] tgt;
   } exp_t;

   exp_t exp_q[$];
   logic chk_valid = 1'b0;
   int   n_assert = 0;
   int   n_fail   = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: on the falling edge, each flagged lookup is checked against the queue head.
   always @(negedge CLK) begin
      if (chk_valid) begin
         if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL scoreboard_empty: got lookup %h expected no check", lookup_pc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check32($sformatf("hit@%h", e.pc),    {31'd0, pred_hit},   {31'd0, e.hit});
            check32($sformatf("taken@%h", e.pc),  {31'd0, pred_taken}, {31'd0, e.taken});
            check32($sformatf("target@%h", e.pc), pred_target,         e.tgt);
         end
      end
   end

   task automatic drive(input logic [31:0] lpc, input logic len,
                        input logic uv, input logic [31:0] upc, input logic ut,
                        input logic [31:0] utg, input logic um,
                        input logic chk, input logic eh, input logic et, input logic [31:0] etg);
      lookup_pc      = lpc;
      lookup_en      = len;
      upd_valid      = uv;
      upd_pc         = upc;
      upd_taken      = ut;
      upd_target     = utg;
      upd_mispredict = um;
      chk_valid      = chk;
      if (chk) exp_q.push_back('{pc: lpc, hit: eh, taken: et, tgt: etg});
      @(posedge CLK);
      #1;
   endtask

   // Lookup-only cycle with a queued expectation.
   task automatic look(input logic [31:0] lpc, input logic eh, input logic et, input logic [31:0] etg);
      drive(lpc, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, eh, et, etg);
   endtask

   // Update cycle, unchecked lookup.
   task automatic upd(input logic [31:0] upc, input logic ut, input logic [31:0] utg, input logic um);
      drive(32'h0, 1'b0, 1'b1, upc, ut, utg, um, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      nRST = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      do_reset();

      // After reset: everything misses and predicts fall-through.
      look(32'h0000_0040, 1'b0, 1'b0, 32'h0000_0044);
      look(32'h0000_1234, 1'b0, 1'b0, 32'h0000_1238);

      // Same-cycle lookup and allocating update: old state, then new state.
      drive(32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 32'h44);
      look(32'h40, 1'b1, 1'b1, 32'h100);

      // Not-taken training 2 -> 1 -> 0 -> 0, target kept; each lookup sees pre-update state.
      drive(32'h40, 1'b1, 1'b1, 32'h40, 1'b0, 32'h999, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100);
      drive(32'h40, 1'b1, 1'b1, 32'h40, 1'b0, 32'h999, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100);
      drive(32'h40, 1'b1, 1'b1, 32'h40, 1'b0, 32'h999, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100);
      look(32'h40, 1'b1, 1'b0, 32'h100);

      // Taken training 0 -> 1 -> 2 -> 3 -> 3 with new target, then one not-taken back to 2.
      upd(32'h40, 1'b1, 32'h200, 1'b1);
      look(32'h40, 1'b1, 1'b0, 32'h200);
      upd(32'h40, 1'b1, 32'h200, 1'b0);
      look(32'h40, 1'b1, 1'b1, 32'h200);
      upd(32'h40, 1'b1, 32'h200, 1'b0);
      upd(32'h40, 1'b1, 32'h200, 1'b0);
      upd(32'h40, 1'b0, 32'h0, 1'b1);
      look(32'h40, 1'b1, 1'b1, 32'h200);

      // upd_valid=0 with live-looking update fields changes nothing (counter 2 would drop to 1).
      drive(32'h40, 1'b1, 1'b0, 32'h40, 1'b0, 32'h777, 1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
      drive(32'h40, 1'b1, 1'b0, 32'h80, 1'b1, 32'h777, 1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
      look(32'h40, 1'b1, 1'b1, 32'h200);

      // Not-taken miss at a conflicting tag leaves the table alone.
      upd(32'h80, 1'b0, 32'h300, 1'b0);
      look(32'h40, 1'b1, 1'b1, 32'h200);
      look(32'h80, 1'b0, 1'b0, 32'h84);

      // Taken miss at same index, different tag: replaces the occupant.
      upd(32'h80, 1'b1, 32'h300, 1'b1);
      look(32'h40, 1'b0, 1'b0, 32'h44);
      look(32'h80, 1'b1, 1'b1, 32'h300);

      // Low PC bits ignored; predictions driven with lookup_en low.
      drive(32'h83, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h300);

      // Independent index.
      upd(32'h44, 1'b1, 32'h500, 1'b1);
      look(32'h44, 1'b1, 1'b1, 32'h500);
      look(32'h80, 1'b1, 1'b1, 32'h300);

      // Update presented during reset is discarded; reset invalidates everything.
      nRST = 1'b0;
      upd(32'h48, 1'b1, 32'h600, 1'b1);
      nRST = 1'b1;
      look(32'h48, 1'b0, 1'b0, 32'h4C);
      look(32'h80, 1'b0, 1'b0, 32'h84);
      look(32'h44, 1'b0, 1'b0, 32'h48);

`ifdef BTB_PERF_EN
      do_reset();
      for (int k = 0; k < 5; k++) upd(32'h40, 1'b1, 32'h100, 1'b1);
      for (int k = 0; k < 3; k++) look(32'h40, 1'b1, 1'b1, 32'h100);
      drive(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check32("perf_updates", perf_updates, 32'd5);
      check32("perf_mispredicts", perf_mispredicts, 32'd5);
      check32("perf_hits", perf_hits, 32'd3);
      nRST = 1'b0;
      drive(32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      nRST = 1'b1;
      check32("perf_updates_rst", perf_updates, 32'd0);
      check32("perf_mispredicts_rst", perf_mispredicts, 32'd0);
      check32("perf_hits_rst", perf_hits, 32'd0);
`endif

      drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check32("scoreboard_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
